// File: rtl/prach_hb2_pair_sched.sv
// Pairs per-channel TDM samples into even/odd beats for prach_hb2_ch.
// Optional PRACH_PAIR_STATS_EN adds pair/drop counters.
module prach_hb2_pair_sched #(
  parameter int NumChannel     = 32,
  parameter int NumChannelUsed = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           din_dq,
  input  logic                  din_dv,
  input  logic [7:0]            din_chn,
  input  logic                  sync_in,
  input  logic [NumChannel-1:0] ch_en,
  output logic [15:0]           dout_dp1,
  output logic [15:0]           dout_dp2,
  output logic                  dout_dv,
  output logic [7:0]            dout_chn,
  output logic                  sync_out,
  output logic                  err_chn,
  input  logic                  err_clr
`ifdef PRACH_PAIR_STATS_EN
  ,
  output logic [31:0]           pair_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int IW = $clog2(NumChannel);
  localparam logic [7:0] UsedW = 8'(NumChannelUsed);

  logic [NumChannel-1:0] phase_q, phase_d;
  logic [15:0]           mem_q [NumChannel];
  logic                  sync_pend_q, sync_pend_d;
  logic                  err_q, err_d;
  logic [15:0]           dp1_q, dp1_d, dp2_q, dp2_d;
  logic                  dv_q, dv_d;
  logic [7:0]            chn_q, chn_d;
  logic                  so_q, so_d;

  logic [IW-1:0] idx;
  logic          legal, en, accept, emit, store;

  always_comb begin
    idx    = din_chn[IW-1:0];
    legal  = din_chn < UsedW;
    en     = ch_en[idx];
    accept = din_dv && legal && en;
    emit   = accept && !sync_in && phase_q[idx];
    store  = accept && (sync_in || !phase_q[idx]);

    // a disable anywhere kills that channel's half-pair
    phase_d = phase_q & ch_en;
    if (sync_in) phase_d = '0;
    if (store) phase_d[idx] = 1'b1;
    if (emit)  phase_d[idx] = 1'b0;

    dv_d  = emit;
    dp1_d = dp1_q;
    dp2_d = dp2_q;
    chn_d = chn_q;
    if (emit) begin
      dp1_d = din_dq;
      dp2_d = mem_q[idx];
      chn_d = din_chn;
    end

    so_d        = emit && (idx == '0) && sync_pend_q;
    sync_pend_d = sync_pend_q;
    if (so_d)    sync_pend_d = 1'b0;
    if (sync_in) sync_pend_d = 1'b1;

    err_d = err_q;
    if (err_clr)          err_d = 1'b0;
    if (din_dv && !legal) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[idx] <= din_dq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      sync_pend_q <= 1'b0;
      err_q       <= 1'b0;
      dp1_q       <= '0;
      dp2_q       <= '0;
      dv_q        <= 1'b0;
      chn_q       <= '0;
      so_q        <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      sync_pend_q <= sync_pend_d;
      err_q       <= err_d;
      dp1_q       <= dp1_d;
      dp2_q       <= dp2_d;
      dv_q        <= dv_d;
      chn_q       <= chn_d;
      so_q        <= so_d;
    end
  end

  assign dout_dp1 = dp1_q;
  assign dout_dp2 = dp2_q;
  assign dout_dv  = dv_q;
  assign dout_chn = chn_q;
  assign sync_out = so_q;
  assign err_chn  = err_q;

`ifdef PRACH_PAIR_STATS_EN
  logic [31:0] pair_q, pair_d;
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;
  logic [NumChannel-1:0] orphan;
  logic [15:0] nd;

  always_comb begin
    orphan = sync_in ? phase_q : (phase_q & ~ch_en);
    nd = '0;
    for (int i = 0; i < NumChannel; i++) nd = nd + 16'(orphan[i]);
    if (din_dv && !(legal && en)) nd = nd + 16'd1;
    drop_sum = {1'b0, drop_q} + {1'b0, nd};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    pair_d   = pair_q;
    if (emit && pair_q != 32'hFFFF_FFFF) pair_d = pair_q + 32'd1;
    if (err_clr) begin
      pair_d = '0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
      drop_q <= '0;
    end else begin
      pair_q <= pair_d;
      drop_q <= drop_d;
    end
  end

  assign pair_cnt = pair_q;
  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_prach_hb2_pair_sched.sv
// Directed bench for prach_hb2_pair_sched.
module tb_prach_hb2_pair_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din_dq;
  logic        din_dv;
  logic [7:0]  din_chn;
  logic        sync_in;
  logic [31:0] ch_en;
  logic [15:0] dout_dp1, dout_dp2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;
  logic        err_chn;
  logic        err_clr;
`ifdef PRACH_PAIR_STATS_EN
  logic [31:0] pair_cnt;
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prach_hb2_pair_sched dut (
    .clk(clk), .rst_n(rst_n),
    .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn),
    .sync_in(sync_in), .ch_en(ch_en),
    .dout_dp1(dout_dp1), .dout_dp2(dout_dp2), .dout_dv(dout_dv),
    .dout_chn(dout_chn), .sync_out(sync_out),
    .err_chn(err_chn), .err_clr(err_clr)
`ifdef PRACH_PAIR_STATS_EN
    , .pair_cnt(pair_cnt), .drop_cnt(drop_cnt)
`endif
  );

  task automatic beat(input int c, input logic [15:0] d, input logic s);
    din_dv = 1'b1;
    din_chn = c[7:0];
    din_dq = d;
    sync_in = s;
    @(posedge clk);
    #1;
    din_dv = 1'b0;
    sync_in = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din_dq = '0; din_dv = 1'b0; din_chn = '0;
    sync_in = 1'b0; ch_en = '1; err_clr = 1'b0;
    #22;
    checks++;
    if ({dout_dv, sync_out, err_chn} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {dout_dv, sync_out, err_chn});
    end
    checks++;
    if ({dout_dp1, dout_dp2, dout_chn} !== 40'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {dout_dp1, dout_dp2, dout_chn});
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_basic_pair();
    beat(0, 16'h0010, 1'b0);
    checks++;
    if (dout_dv !== 1'b0) begin
      failures++;
      $display("FAIL basic_first_dv got=%b exp=0", dout_dv);
    end
    beat(0, 16'h0020, 1'b0);
    checks++;
    if ({dout_dv, sync_out, dout_chn, dout_dp2, dout_dp1} !==
        {1'b1, 1'b0, 8'd0, 16'h0010, 16'h0020}) begin
      failures++;
      $display("FAIL basic_pair got dv=%b so=%b chn=%0d dp2=%h dp1=%h exp 1 0 0 0010 0020",
               dout_dv, sync_out, dout_chn, dout_dp2, dout_dp1);
    end
    idle();
    checks++;
    if (dout_dv !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse got=%b exp=0", dout_dv);
    end
  endtask

  task automatic test_interleave();
    int pairs = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 24; c++) begin
        beat(c, 16'(c * 2 + r), 1'b0);
        if (dout_dv === 1'b1) pairs++;
        checks++;
        if (r == 0 && dout_dv !== 1'b0) begin
          failures++;
          $display("FAIL ilv_r0 chn=%0d dv=%b exp=0", c, dout_dv);
        end else if (r == 1 &&
            {dout_dv, dout_chn, dout_dp2, dout_dp1} !==
            {1'b1, 8'(c), 16'(2 * c), 16'(2 * c + 1)}) begin
          failures++;
          $display("FAIL ilv_pair chn=%0d got dv=%b chn=%0d dp2=%h dp1=%h",
                   c, dout_dv, dout_chn, dout_dp2, dout_dp1);
        end
      end
    end
    checks++;
    if (pairs != 24) begin
      failures++;
      $display("FAIL ilv_count got=%0d exp=24", pairs);
    end
  endtask

  task automatic test_sync();
    beat(5, 16'h1111, 1'b0);
    beat(5, 16'h2222, 1'b1);
    checks++;
    if (dout_dv !== 1'b0) begin
      failures++;
      $display("FAIL sync_nopair got=%b exp=0", dout_dv);
    end
    beat(5, 16'h3333, 1'b0);
    checks++;
    if ({dout_dv, dout_chn, dout_dp2, dout_dp1, sync_out} !==
        {1'b1, 8'd5, 16'h2222, 16'h3333, 1'b0}) begin
      failures++;
      $display("FAIL sync_realign got dv=%b chn=%0d dp2=%h dp1=%h so=%b",
               dout_dv, dout_chn, dout_dp2, dout_dp1, sync_out);
    end
    beat(0, 16'h0A00, 1'b0);
    beat(0, 16'h0A01, 1'b0);
    checks++;
    if ({dout_dv, sync_out, dout_chn} !== {1'b1, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL sync_out_first got dv=%b so=%b chn=%0d exp 1 1 0",
               dout_dv, sync_out, dout_chn);
    end
    beat(0, 16'h0B00, 1'b0);
    beat(0, 16'h0B01, 1'b0);
    checks++;
    if ({dout_dv, sync_out, dout_dp2, dout_dp1} !==
        {1'b1, 1'b0, 16'h0B00, 16'h0B01}) begin
      failures++;
      $display("FAIL sync_out_second got dv=%b so=%b dp2=%h dp1=%h",
               dout_dv, sync_out, dout_dp2, dout_dp1);
    end
  endtask

  task automatic test_err();
    beat(24, 16'hDEAD, 1'b0);
    checks++;
    if ({dout_dv, err_chn} !== 2'b01) begin
      failures++;
      $display("FAIL err_set got dv=%b err=%b exp 0 1", dout_dv, err_chn);
    end
    idle();
    idle();
    checks++;
    if (err_chn !== 1'b1) begin
      failures++;
      $display("FAIL err_hold got=%b exp=1", err_chn);
    end
    err_clr = 1'b1;
    idle();
    checks++;
    if (err_chn !== 1'b0) begin
      failures++;
      $display("FAIL err_clr got=%b exp=0", err_chn);
    end
    err_clr = 1'b1;
    beat(30, 16'hBEEF, 1'b0);
    checks++;
    if ({dout_dv, err_chn} !== 2'b01) begin
      failures++;
      $display("FAIL err_set_wins got dv=%b err=%b exp 0 1", dout_dv, err_chn);
    end
    err_clr = 1'b1;
    idle();
  endtask

  task automatic test_disable();
    ch_en[3] = 1'b0;
    beat(3, 16'hAAAA, 1'b0);
    beat(3, 16'hBBBB, 1'b0);
    checks++;
    if ({dout_dv, err_chn} !== 2'b00) begin
      failures++;
      $display("FAIL dis_drop got dv=%b err=%b exp 0 0", dout_dv, err_chn);
    end
    ch_en[3] = 1'b1;
    beat(3, 16'hCCCC, 1'b0);
    checks++;
    if (dout_dv !== 1'b0) begin
      failures++;
      $display("FAIL dis_reen_first got=%b exp=0", dout_dv);
    end
    beat(3, 16'hDDDD, 1'b0);
    checks++;
    if ({dout_dv, dout_chn, dout_dp2, dout_dp1} !==
        {1'b1, 8'd3, 16'hCCCC, 16'hDDDD}) begin
      failures++;
      $display("FAIL dis_reen_pair got dv=%b chn=%0d dp2=%h dp1=%h",
               dout_dv, dout_chn, dout_dp2, dout_dp1);
    end
    beat(9, 16'h0900, 1'b0);
    ch_en[9] = 1'b0;
    idle();
    ch_en[9] = 1'b1;
    beat(9, 16'h0901, 1'b0);
    checks++;
    if (dout_dv !== 1'b0) begin
      failures++;
      $display("FAIL dis_straddle got=%b exp=0", dout_dv);
    end
  endtask

  task automatic test_async_reset();
    beat(7, 16'h5555, 1'b0);
    beat(1, 16'h0101, 1'b0);
    beat(1, 16'h0102, 1'b0);
    checks++;
    if (dout_dv !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got=%b exp=1", dout_dv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_dv !== 1'b0) begin
      failures++;
      $display("FAIL arst_async got=%b exp=0", dout_dv);
    end
    #3;
    rst_n = 1'b1;
    idle();
    beat(7, 16'h0001, 1'b0);
    checks++;
    if (dout_dv !== 1'b0) begin
      failures++;
      $display("FAIL arst_first got=%b exp=0", dout_dv);
    end
    beat(7, 16'h0002, 1'b0);
    checks++;
    if ({dout_dv, dout_chn, dout_dp2, dout_dp1} !==
        {1'b1, 8'd7, 16'h0001, 16'h0002}) begin
      failures++;
      $display("FAIL arst_pair got dv=%b chn=%0d dp2=%h dp1=%h",
               dout_dv, dout_chn, dout_dp2, dout_dp1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_interleave();
    test_sync();
    test_err();
    test_disable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prach_hb2_pair_sched.md
Name: prach_hb2_pair_sched

Overview:
Polyphase pairing scheduler placed directly upstream of the PRACH halfband-by-2 decimator channel (prach_hb2_ch).
- Accepts a full-rate TDM sample stream (one 16-bit sample per beat, tagged with channel number).
- Per channel, collects consecutive samples into even/odd pairs and issues each complete pair as one decimator beat (dp1/dp2, dv, chn, sync).
- Also enforces channel enables, realigns pair phase on frame sync, and flags illegal channel tags.

Parameters:
NumChannel, 32, TDM slots / channel-number space; sizes the phase and storage arrays.
NumChannelUsed, 24, channels 0..NumChannelUsed-1 are legal; tags at or above this value are errors.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
din_dq  in  16  input sample, signed two's complement
din_dv  in  1  din_dq/din_chn valid this cycle
din_chn  in  8  channel tag of din_dq
sync_in  in  1  frame sync pulse; realigns all channel phases
ch_en  in  NumChannel  per-channel enable; quasi-static
dout_dp1  out  16  odd-phase (second) sample of pair
dout_dp2  out  16  even-phase (first) sample of pair
dout_dv  out  1  pair valid, single-cycle pulse
dout_chn  out  8  channel of pair
sync_out  out  1  marks first pair of channel 0 after a sync_in
err_chn  out  1  sticky: an illegal channel tag was received
err_clr  in  1  clears err_chn

Behaviour:
- Single clock domain, single asynchronous active-low reset rst_n.
- State:
  - phase[NumChannel]: 1-bit per channel, reset 0.
  - mem[NumChannel]: 16-bit per channel, not reset; contents are don't-care while phase=0.
  - sync_pend: 1-bit, reset 0.
  - err_chn: reset 0.
- Reset values of outputs: dout_dv=0, sync_out=0, err_chn=0, dout_dp1/dp2/chn=0.
- Accepted sample: din_dv=1, din_chn<NumChannelUsed, ch_en[din_chn]=1, sync_in=0.
  - Phase 0: mem[chn] <= din_dq; phase[chn] <= 1; no output.
  - Phase 1: phase[chn] <= 0; next cycle dout_dv=1, dout_dp2=mem[chn], dout_dp1=din_dq, dout_chn=chn.
- Latency: completing sample to dout_dv is exactly 1 cycle (registered outputs).
- Throughput: din_dv may be high every cycle; at most one pair per cycle out; no backpressure.
- Disabled channel (ch_en[chn]=0): sample dropped, phase[chn] forced to 0, no error.
- Illegal tag (din_chn>=NumChannelUsed with din_dv=1): sample dropped, err_chn <= 1.
- err_chn stays 1 until err_clr=1 (one cycle). Simultaneous new error and err_clr: err_chn stays 1 (set wins).
- sync_in=1 (any din_dv):
  - All phase bits clear to 0; sync_pend <= 1.
  - If din_dv=1 in the same cycle and the sample is acceptable, it is stored as phase 0 of its channel (post-clear) and no pair is emitted.
- sync_out:
  - Asserted together with dout_dv for the first emitted pair with dout_chn=0 while sync_pend=1; sync_pend then clears.
  - Never asserted without dout_dv.
  - If ch_en[0]=0, sync_pend stays set until channel 0 is re-enabled and emits.
- Arithmetic: pure data movement, no width change, no rounding; dp1/dp2 bit-exact copies.
- Only the low ceil(log2(NumChannel)) bits of din_chn index the arrays, after the legality check.
- Reset mid-pair: partially collected pairs are discarded (phase=0); the first post-reset sample of each channel is phase 0.
- ch_en change mid-pair: a pair straddling the disable is discarded.

Optional Feature:
PRACH_PAIR_STATS_EN
- Defined: adds outputs pair_cnt[31:0] (emitted pairs) and drop_cnt[15:0] (dropped samples: illegal, disabled, or orphan phase-0 sample destroyed by sync/disable).
  - Both counters saturate, reset to 0, and clear on err_clr.
- Not defined: ports and counters absent; core behaviour identical.

Test Plan:
1. Reset, ch_en=all 1, feed ch0 samples 0x0010 then 0x0020 -> one cycle after the second sample: dout_dv=1, dout_chn=0, dout_dp2=0x0010, dout_dp1=0x0020; no output after the first sample.
2. Interleaved chn 0..23, two rounds, data=chn*2+round, din_dv every cycle -> exactly 24 pairs in order 0..23, each dp2=2*chn, dp1=2*chn+1.
3. ch5 sample 0x1111, then sync_in with ch5 sample 0x2222, then ch5 0x3333 -> single pair dp2=0x2222, dp1=0x3333; first subsequent ch0 pair has sync_out=1, the next ch0 pair sync_out=0.
4. din_chn=24 with din_dv=1 -> no dout_dv, err_chn=1 next cycle and held; err_clr pulse -> err_chn=0; err_clr coincident with another chn=30 -> err_chn stays 1.
5. ch_en[3]=0: feed ch3 0xAAAA,0xBBBB -> no output; re-enable, feed 0xCCCC,0xDDDD -> pair dp2=0xCCCC, dp1=0xDDDD.
6. Assert rst_n=0 asynchronously between the two samples of ch7 -> dout_dv=0 immediately; after release, ch7 samples 0x0001,0x0002 -> pair dp2=0x0001, dp1=0x0002.
